// File: rtl/rs_pkg.sv
// Shared Reed-Solomon constants for the GF(256) encoder and decoder.
// Generator roots are a^0..a^3 with a=0x02 over primitive polynomial 0x11D.
package rs_pkg;

  localparam logic [8:0] GF_PRIM = 9'h11D;
  localparam int RS_NPAR = 4;

  // GEN[i] is the x^i coefficient of the monic degree-4 generator
  localparam logic [RS_NPAR-1:0][7:0] GEN = {
    8'h0F, 8'h36, 8'h78, 8'h40
  };

  typedef enum logic {
    MSG,
    PAR
  } enc_state_t;

endpackage

// File: rtl/gf256_mult.sv
// Combinational GF(256) multiplier, shift-and-add reduced by GF_PRIM.
// Shared by the encoder parity network and the decoder syndrome path.
module gf256_mult (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  import rs_pkg::*;

  logic [7:0] sh;

  always_comb begin
    y  = '0;
    sh = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) y = y ^ sh;
      sh = {sh[6:0], 1'b0}
         ^ (sh[7] ? GF_PRIM[7:0] : 8'h00);
    end
  end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(N,K) encoder: passes K message symbols through,
// then appends 4 parity symbols from an LFSR divider by g(x).
module rs_encoder #(
  parameter int N = 32,
  parameter int K = 28
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_first,
  output logic       o_last
);
  import rs_pkg::*;

  localparam logic [4:0] LAST_MSG = 5'(K - 1);
  localparam logic [1:0] TOP_IDX  = 2'(N - K - 1);

  enc_state_t state, state_nx;

  logic [4:0] count;
  logic [1:0] idx;
  logic [RS_NPAR-1:0][7:0] p;
  logic [RS_NPAR-1:0][7:0] prod;
  logic [7:0] fb;
  logic out_free;
  logic accept;
  logic emit;

  assign out_free = !o_valid || i_ready;
  assign fb = i_data ^ p[3];

  for (genvar g = 0; g < RS_NPAR; g++) begin : g_mul
    gf256_mult u_mult (
      .a (fb),
      .b (GEN[g]),
      .y (prod[g])
    );
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    accept   = 1'b0;
    emit     = 1'b0;
    case (state)
      MSG: begin
        o_ready = out_free;
        accept  = i_valid && out_free;
        if (accept && count == LAST_MSG)
          state_nx = PAR;
      end
      PAR: begin
        emit = out_free;
        if (emit && idx == 2'd0)
          state_nx = MSG;
      end
      default: state_nx = MSG;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= MSG;
    else          state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      p       <= '0;
      count   <= '0;
      idx     <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_first <= (count == 5'd0);
      o_last  <= 1'b0;
      p[3]    <= p[2] ^ prod[3];
      p[2]    <= p[1] ^ prod[2];
      p[1]    <= p[0] ^ prod[1];
      p[0]    <= prod[0];
      count   <= count + 5'd1;
      if (count == LAST_MSG) idx <= TOP_IDX;
    end else if (emit) begin
      o_valid <= 1'b1;
      o_data  <= p[idx];
      o_first <= 1'b0;
      o_last  <= (idx == 2'd0);
      idx     <= idx - 2'd1;
      // last parity out: ready the divider for a fresh codeword
      if (idx == 2'd0) begin
        p     <= '0;
        count <= '0;
      end
    end else if (out_free) begin
      o_valid <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: log/antilog GF model, polynomial long division
// reference, syndrome checks, throttling, mid-codeword reset, C2 build.
module tb_rs_encoder;

  localparam int N  = 32;
  localparam int K  = 28;
  localparam int N2 = 28;
  localparam int K2 = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_first;
  logic       out_last;

  logic       c2_valid = 1'b0;
  logic       c2_in_ready;
  logic [7:0] c2_data = '0;
  logic       c2_out_valid;
  logic       c2_ready = 1'b1;
  logic [7:0] c2_out_data;
  logic       c2_first;
  logic       c2_last;

  always #5 clk = ~clk;

  rs_encoder #(.N(N), .K(K)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (in_data),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_first (out_first),
    .o_last  (out_last)
  );

  rs_encoder #(.N(N2), .K(K2)) dut_c2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (c2_valid),
    .o_ready (c2_in_ready),
    .i_data  (c2_data),
    .o_valid (c2_out_valid),
    .i_ready (c2_ready),
    .o_data  (c2_out_data),
    .o_first (c2_first),
    .o_last  (c2_last)
  );

  int vectors = 0;
  int miscompares = 0;
  int stalls = 0;

  logic [7:0] exp_t [255];
  int         log_t [256];
  logic [7:0] gen [5];
  logic [7:0] msg [K];
  logic [9:0] out_q [$];
  logic [9:0] c2_q [$];
  logic [9:0] saved_q [$];

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic chk(
    input string tag,
    input logic [15:0] obs,
    input logic [15:0] want
  );
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, want);
    end
  endtask

  // one clock: sample at negedge, return at posedge+1
  task automatic cycle(output bit acc, output bit c2acc);
    @(negedge clk);
    acc   = in_valid && in_ready;
    c2acc = c2_valid && c2_in_ready;
    if (out_valid && out_ready) begin
      out_q.push_back({out_first, out_last, out_data});
      if (!in_ready) stalls++;
    end
    if (c2_out_valid && c2_ready)
      c2_q.push_back({c2_first, c2_last, c2_out_data});
    @(posedge clk);
    #1;
  endtask

  task automatic run_cw(input bit thr);
    bit acc, c2a;
    int idx, cyc;
    idx = 0;
    cyc = 0;
    out_q.delete();
    stalls = 0;
    while (out_q.size() < N && cyc < 1000) begin
      in_valid  = (idx < K) && (!thr || $urandom_range(1, 0) == 1);
      in_data   = (idx < K) ? msg[idx] : 8'($urandom);
      out_ready = !thr || $urandom_range(1, 0) == 1;
      cycle(acc, c2a);
      if (acc) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("cw_len", 16'(out_q.size()), 16'(N));
  endtask

  task automatic check_cw(input string tag);
    logic [7:0] r [N];
    logic [7:0] c, s;
    logic [9:0] want, obs;
    for (int j = 0; j < N; j++)
      r[j] = (j < K) ? msg[j] : 8'h00;
    for (int i = 0; i < K; i++) begin
      c = r[i];
      for (int j = 0; j <= 4; j++)
        r[i+j] = r[i+j] ^ gmul(c, gen[4-j]);
    end
    for (int j = 0; j < N; j++) begin
      want = {j == 0, j == N - 1,
              (j < K) ? msg[j] : r[j]};
      obs  = (j < out_q.size()) ? out_q[j] : 10'h3FF;
      chk($sformatf("%s_sym%0d", tag, j),
          16'(obs), 16'(want));
    end
    for (int i = 0; i < 4; i++) begin
      s = 8'h00;
      for (int j = 0; j < out_q.size(); j++)
        s = gmul(s, exp_t[i]) ^ out_q[j][7:0];
      chk($sformatf("%s_syn%0d", tag, i), 16'(s), 16'h0);
    end
    chk({tag, "_stall"}, 16'(stalls), 16'd4);
  endtask

  task automatic rand_msg();
    for (int j = 0; j < K; j++) msg[j] = 8'($urandom);
  endtask

  initial begin
    logic [8:0] v;
    logic [7:0] x;
    bit acc, c2a;
    int idx, cyc;

    v = 9'h001;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v[7:0];
      log_t[v[7:0]] = i;
      v = v << 1;
      if (v[8]) v = v ^ 9'h11D;
    end
    gen[0] = 8'h01;
    for (int k = 1; k < 5; k++) gen[k] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      for (int k = 4; k >= 1; k--)
        gen[k] = gen[k-1] ^ gmul(exp_t[i], gen[k]);
      gen[0] = gmul(exp_t[i], gen[0]);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_data",  16'(out_data),  16'd0);
    chk("rst_first", 16'(out_first), 16'd0);
    chk("rst_last",  16'(out_last),  16'd0);
    chk("rst_ready", 16'(in_ready),  16'd1);
    rst_n = 1'b1;

    for (int j = 0; j < K; j++) msg[j] = 8'h00;
    run_cw(1'b0);
    check_cw("zero");

    msg[K-1] = 8'h01;
    run_cw(1'b0);
    check_cw("unit");
    chk("unit_p3", 16'(out_q[K][7:0]),   16'h0F);
    chk("unit_p2", 16'(out_q[K+1][7:0]), 16'h36);
    chk("unit_p1", 16'(out_q[K+2][7:0]), 16'h78);
    chk("unit_p0", 16'(out_q[K+3][7:0]), 16'h40);
    x = 8'h00;
    foreach (out_q[j]) x = x ^ out_q[j][7:0];
    chk("unit_xor", 16'(x), 16'h0);

    for (int n = 0; n < 600; n++) begin
      rand_msg();
      run_cw(1'b0);
      check_cw("rand");
    end

    for (int n = 0; n < 200; n++) begin
      rand_msg();
      run_cw(1'b0);
      check_cw("free");
      saved_q = out_q;
      run_cw(1'b1);
      check_cw("thr");
      for (int j = 0; j < N; j++)
        chk($sformatf("thr_same%0d", j),
            16'((j < out_q.size()) ? out_q[j] : 10'h3FF),
            16'(saved_q[j]));
    end

    rand_msg();
    idx = 0;
    cyc = 0;
    while (idx < 11 && cyc < 100) begin
      in_valid = 1'b1;
      in_data  = msg[idx];
      cycle(acc, c2a);
      if (acc) idx++;
      cyc++;
    end
    chk("mid_acc", 16'(idx), 16'd11);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    chk("mid_valid_edge", 16'(out_valid), 16'd0);
    chk("mid_data", 16'(out_data), 16'd0);
    chk("mid_first", 16'(out_first), 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_msg();
    run_cw(1'b0);
    check_cw("post_rst");

    c2_q.delete();
    idx = 0;
    cyc = 0;
    while (c2_q.size() < N2 && cyc < 200) begin
      c2_valid = (idx < K2);
      c2_data  = (idx == K2 - 1) ? 8'h01 : 8'h00;
      cycle(acc, c2a);
      if (c2a) idx++;
      cyc++;
    end
    c2_valid = 1'b0;
    chk("c2_len", 16'(c2_q.size()), 16'(N2));
    if (c2_q.size() == N2) begin
      chk("c2_first", 16'(c2_q[0][9]), 16'd1);
      chk("c2_msg_end", 16'(c2_q[K2-1]), 16'h001);
      chk("c2_p3", 16'(c2_q[K2]),   16'h00F);
      chk("c2_p2", 16'(c2_q[K2+1]), 16'h036);
      chk("c2_p1", 16'(c2_q[K2+2]), 16'h078);
      chk("c2_p0", 16'(c2_q[K2+3]), 16'h140);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
